// File: rtl/store_trace_checker.sv
// Watches CPU data-memory stores and checks them in order against a runtime-programmed list of (addr, data) pairs.
// Stores inside a scratch window are tolerated. Pass/fail status is sticky and appears one cycle after the deciding store.
module store_trace_checker #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEPTH    = 8,
  parameter int IGN_BASE = 96,
  parameter int IGN_SIZE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CW       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [DW-1:0]              cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_count,
  input  logic                       start,
  input  logic                       MemWrite,
  input  logic [AW-1:0]              DataAdr,
  input  logic [DW-1:0]              WriteData,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [$clog2(DEPTH):0]     match_cnt,
  output logic [7:0]                 ign_cnt,
  output logic [AW-1:0]              fail_addr,
  output logic [DW-1:0]              fail_data,
  output logic [CW-1:0]              cycles
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0]   DEPTH_C = (IW+1)'(DEPTH);
  localparam logic [AW:0]   IGN_LO  = (AW+1)'(IGN_BASE);
  localparam logic [AW:0]   IGN_HI  = (AW+1)'(IGN_BASE + IGN_SIZE);
  localparam logic [CW-1:0] TO_M1   = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] exp_addr [DEPTH];
  logic [DW-1:0] exp_data [DEPTH];
  logic [IW:0]   count, count_clamped;
  logic [IW-1:0] idx;
  logic          hit_addr, hit_data, in_ign;
  logic          adv, ign, capture;
  logic [1:0]    code_nxt;

  assign busy = (state == RUN);
  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    code_nxt      = 2'd0;
    adv           = 1'b0;
    ign           = 1'b0;
    capture       = 1'b0;
    count_clamped = (cfg_count > DEPTH_C) ? DEPTH_C : cfg_count;
    hit_addr      = (DataAdr == exp_addr[idx]);
    hit_data      = (WriteData == exp_data[idx]);
    in_ign        = (IGN_SIZE != 0) && ({1'b0, DataAdr} >= IGN_LO) && ({1'b0, DataAdr} < IGN_HI);
    case (state)
      RUN: begin
        if (MemWrite) begin
          if (hit_addr && hit_data) begin
            adv = 1'b1;
            if (({1'b0, idx} + (IW+1)'(1)) == count) state_nxt = PASS;
          end else if (hit_addr) begin
            state_nxt = FAIL;
            code_nxt  = 2'd2;
            capture   = 1'b1;
          end else if (in_ign) begin
            ign = 1'b1;
          end else begin
            state_nxt = FAIL;
            code_nxt  = 2'd1;
            capture   = 1'b1;
          end
        end
        // A store that already decided the run wins over the timeout.
        if ((TIMEOUT != 0) && (state_nxt == RUN) && (cycles == TO_M1)) begin
          state_nxt = FAIL;
          code_nxt  = 2'd3;
        end
      end
      default: begin
        if (start) state_nxt = (count_clamped == '0) ? PASS : RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        exp_addr[i] <= '0;
        exp_data[i] <= '0;
      end
      count     <= '0;
      idx       <= '0;
      match_cnt <= '0;
      ign_cnt   <= '0;
      cycles    <= '0;
      fail_code <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (state != RUN) begin
      if (cfg_we) begin
        exp_addr[cfg_idx] <= cfg_addr;
        exp_data[cfg_idx] <= cfg_data;
      end
      if (start) begin
        count     <= count_clamped;
        idx       <= '0;
        match_cnt <= '0;
        ign_cnt   <= '0;
        cycles    <= '0;
        fail_code <= '0;
        fail_addr <= '0;
        fail_data <= '0;
      end
    end else begin
      if (cycles != '1) cycles <= cycles + CW'(1);
      if (adv) begin
        idx       <= idx + IW'(1);
        match_cnt <= match_cnt + (IW+1)'(1);
      end
      if (ign && (ign_cnt != 8'hFF)) ign_cnt <= ign_cnt + 8'd1;
      if (capture) begin
        fail_addr <= DataAdr;
        fail_data <= WriteData;
      end
      fail_code <= code_nxt;
    end
  end
endmodule

// File: tb/tb_store_trace_checker.sv
// Bench for store_trace_checker: directed scenarios plus randomized traces checked against a trace-level model.
module tb_store_trace_checker;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [3:0]  cfg_count;
  logic        start;
  logic        MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic        busy, done, pass;
  logic [1:0]  fail_code;
  logic [3:0]  match_cnt;
  logic [7:0]  ign_cnt;
  logic [31:0] fail_addr, fail_data;
  logic [15:0] cycles;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_addr [8];
  logic [31:0] m_data [8];
  int          mcount;
  logic        s_vld  [64];
  logic [31:0] s_addr [64];
  logic [31:0] s_data [64];

  logic        e_busy, e_done, e_pass;
  logic [1:0]  e_code;
  logic [3:0]  e_match;
  logic [7:0]  e_ign;
  logic [31:0] e_fa, e_fd;
  logic [15:0] e_cyc;
  logic [96:0] o_v, e_v;

  always #5 clk = ~clk;

  store_trace_checker #(.AW(32), .DW(32), .DEPTH(8), .IGN_BASE(96), .IGN_SIZE(4),
                        .TIMEOUT(TMO), .CW(16)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .busy(busy), .done(done), .pass(pass),
    .fail_code(fail_code), .match_cnt(match_cnt), .ign_cnt(ign_cnt), .fail_addr(fail_addr),
    .fail_data(fail_data), .cycles(cycles)
  );

  function automatic logic [96:0] obs_vec();
    return {busy, done, pass, fail_code, match_cnt, ign_cnt, fail_addr, fail_data, cycles};
  endfunction

  function automatic logic [96:0] exp_vec();
    return {e_busy, e_done, e_pass, e_code, e_match, e_ign, e_fa, e_fd, e_cyc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic program_entry(input int i, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
    m_addr[i] = a; m_data[i] = d;
  endtask

  task automatic do_start(input int cnt);
    cfg_count = 4'(cnt); start = 1'b1;
    cyc();
    start = 1'b0;
    mcount = (cnt > 8) ? 8 : cnt;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      s_vld[i] = 1'b0; s_addr[i] = '0; s_data[i] = '0;
    end
  endtask

  task automatic set_stim(input int c, input logic [31:0] a, input logic [31:0] d);
    s_vld[c] = 1'b1; s_addr[c] = a; s_data[c] = d;
  endtask

  task automatic drive(input int from, input int to);
    for (int c = from; c < to; c++) begin
      MemWrite = s_vld[c]; DataAdr = s_addr[c]; WriteData = s_data[c];
      cyc();
    end
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
  endtask

  // Replays the whole trace from the start of the run: walk the expected list in order,
  // tolerate window stores, stop on the first verdict, time out after TMO idle-verdict edges.
  task automatic model_run(input int ncyc);
    logic [15:0] prev;
    e_busy = 1'b1; e_done = 1'b0; e_pass = 1'b0; e_code = 2'd0; e_match = '0;
    e_ign = '0; e_fa = '0; e_fd = '0; e_cyc = '0;
    if (mcount == 0) begin
      e_busy = 1'b0; e_done = 1'b1; e_pass = 1'b1;
      return;
    end
    for (int c = 0; c < ncyc; c++) begin
      if (!e_busy) break;
      prev  = e_cyc;
      e_cyc = (e_cyc == 16'hFFFF) ? e_cyc : e_cyc + 16'd1;
      if (s_vld[c]) begin
        if (s_addr[c] == m_addr[e_match[2:0]] && s_data[c] == m_data[e_match[2:0]]) begin
          e_match = e_match + 4'd1;
          if (int'(e_match) == mcount) begin
            e_busy = 1'b0; e_done = 1'b1; e_pass = 1'b1;
          end
        end else if (s_addr[c] == m_addr[e_match[2:0]]) begin
          e_busy = 1'b0; e_done = 1'b1; e_code = 2'd2; e_fa = s_addr[c]; e_fd = s_data[c];
        end else if (s_addr[c] >= 32'd96 && s_addr[c] < 32'd100) begin
          if (e_ign != 8'hFF) e_ign = e_ign + 8'd1;
        end else begin
          e_busy = 1'b0; e_done = 1'b1; e_code = 2'd1; e_fa = s_addr[c]; e_fd = s_data[c];
        end
      end
      if (e_busy && int'(prev) == TMO - 1) begin
        e_busy = 1'b0; e_done = 1'b1; e_code = 2'd3;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) cyc();
    o_v = obs_vec();
    total++;
    if (o_v !== 97'd0) begin
      bad++; $display("FAIL reset_state: got %h want 0", o_v);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_ignore_pass();
    program_entry(0, 32'd100, 32'd25);
    clear_stim();
    set_stim(0, 32'd96, 32'd7); set_stim(1, 32'd96, 32'd9); set_stim(2, 32'd100, 32'd25);
    do_start(1); drive(0, 3); model_run(3);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || pass !== 1'b1 || ign_cnt !== 8'd2) begin
      bad++; $display("FAIL ignore_pass: got %h want %h", o_v, e_v);
    end
    set_stim(3, 32'd200, 32'd1);
    drive(3, 4); model_run(4);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v) begin
      bad++; $display("FAIL pass_sticky: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_data_mismatch();
    program_entry(0, 32'd100, 32'd25);
    clear_stim(); set_stim(0, 32'd100, 32'd24);
    do_start(1); drive(0, 1); model_run(1);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || fail_code !== 2'd2 || fail_data !== 32'd24) begin
      bad++; $display("FAIL data_mismatch: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_bad_addr();
    clear_stim(); set_stim(0, 32'd104, 32'd25);
    do_start(1); drive(0, 1); model_run(1);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || fail_code !== 2'd1 || fail_addr !== 32'd104) begin
      bad++; $display("FAIL bad_addr: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_timeout();
    clear_stim();
    do_start(1); drive(0, TMO - 1); model_run(TMO - 1);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || busy !== 1'b1) begin
      bad++; $display("FAIL timeout_pre: got %h want %h", o_v, e_v);
    end
    drive(TMO - 1, TMO); model_run(TMO);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || fail_code !== 2'd3 || cycles !== 16'(TMO)) begin
      bad++; $display("FAIL timeout: got %h want %h", o_v, e_v);
    end
    clear_stim(); set_stim(TMO - 1, 32'd100, 32'd25);
    do_start(1); drive(0, TMO); model_run(TMO);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || pass !== 1'b1) begin
      bad++; $display("FAIL store_beats_timeout: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_order();
    program_entry(0, 32'd100, 32'd1);
    program_entry(1, 32'd104, 32'd2);
    program_entry(2, 32'd108, 32'd3);
    clear_stim(); set_stim(0, 32'd104, 32'd2); set_stim(1, 32'd100, 32'd1);
    do_start(3); drive(0, 2); model_run(2);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || fail_code !== 2'd1) begin
      bad++; $display("FAIL out_of_order: got %h want %h", o_v, e_v);
    end
    clear_stim();
    set_stim(0, 32'd100, 32'd1); set_stim(2, 32'd104, 32'd2); set_stim(3, 32'd108, 32'd3);
    do_start(3); drive(0, 5); model_run(5);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || match_cnt !== 4'd3) begin
      bad++; $display("FAIL in_order: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_cfg_in_run();
    program_entry(0, 32'd100, 32'd25);
    clear_stim(); set_stim(1, 32'd100, 32'd25);
    do_start(1);
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 32'd200; cfg_data = 32'd5;
    cyc();
    cfg_we = 1'b0;
    drive(1, 2); model_run(2);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v) begin
      bad++; $display("FAIL cfg_ignored_in_run: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 8; i++) program_entry(i, 32'(200 + 4 * i), 32'(i + 10));
    clear_stim();
    for (int i = 0; i < 8; i++) set_stim(i, m_addr[i], m_data[i]);
    do_start(15); drive(0, 8); model_run(8);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || match_cnt !== 4'd8) begin
      bad++; $display("FAIL count_clamp: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_reset_midrun();
    program_entry(0, 32'd100, 32'd1);
    program_entry(1, 32'd104, 32'd2);
    program_entry(2, 32'd108, 32'd3);
    clear_stim(); set_stim(0, 32'd100, 32'd1);
    do_start(3); drive(0, 1); model_run(1);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v) begin
      bad++; $display("FAIL midrun_pre: got %h want %h", o_v, e_v);
    end
    #2 reset = 1'b1;
    #2 o_v = obs_vec();
    total++;
    if (o_v !== 97'd0) begin
      bad++; $display("FAIL reset_async: got %h want 0", o_v);
    end
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_addr[i] = '0; m_data[i] = '0;
    end
    clear_stim();
    do_start(0); model_run(0);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v || pass !== 1'b1) begin
      bad++; $display("FAIL restart_count0: got %h want %h", o_v, e_v);
    end
    set_stim(0, 32'd0, 32'd0);
    do_start(1); drive(0, 1); model_run(1);
    o_v = obs_vec(); e_v = exp_vec();
    total++;
    if (o_v !== e_v) begin
      bad++; $display("FAIL table_cleared: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_random();
    int cnt, eff, gp, r;
    for (int it = 0; it < 20; it++) begin
      cnt = $urandom_range(1, 15);
      eff = (cnt > 8) ? 8 : cnt;
      gp  = 0;
      for (int i = 0; i < 8; i++)
        program_entry(i, 32'(4 * $urandom_range(22, 28)), 32'($urandom_range(0, 3)));
      clear_stim();
      for (int c = 0; c < TMO + 2; c++) begin
        r = $urandom_range(0, 99);
        if (r < 45) begin
          set_stim(c, m_addr[gp], m_data[gp]);
          if (gp < eff - 1) gp++;
        end else if (r < 60) set_stim(c, 32'(96 + $urandom_range(0, 3)), $urandom);
        else if (r < 68) set_stim(c, m_addr[gp], m_data[gp] ^ 32'd1);
        else if (r < 74) set_stim(c, 32'(4 * $urandom_range(22, 28)), 32'($urandom_range(0, 3)));
      end
      do_start(cnt); drive(0, TMO + 2); model_run(TMO + 2);
      o_v = obs_vec(); e_v = exp_vec();
      total++;
      if (o_v !== e_v) begin
        bad++; $display("FAIL random_%0d: got %h want %h", it, o_v, e_v);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_count = '0; start = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    mcount = 0;
    for (int i = 0; i < 8; i++) begin
      m_addr[i] = '0; m_data[i] = '0;
    end
    clear_stim();
    test_reset();
    test_ignore_pass();
    test_data_mismatch();
    test_bad_addr();
    test_timeout();
    test_order();
    test_cfg_in_run();
    test_clamp();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
